// File: rtl/hero_write_arb.sv
// hero_write_arb: round-robin arbiter sharing one hero write bus between
// NUM_REQ producers. A grant holds for a whole VALID..DONE transaction, the
// output beat is registered, and a watchdog truncates overlong bursts.
module hero_write_arb #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned HERO_WIDTH = 36,
   parameter int unsigned SUB_WIDTH  = 7,
   parameter int unsigned MAX_BURST  = 16,
   localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [2*NUM_REQ-1:0]           req_cycle_type,
   input  logic [HERO_WIDTH*NUM_REQ-1:0]  req_wdat,
   input  logic [SUB_WIDTH*NUM_REQ-1:0]   req_sub,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           out_ready,
   output logic [1:0]                     hero_cycle_type,
   output logic [HERO_WIDTH-1:0]          hero_wdat,
   output logic [SUB_WIDTH-1:0]           hero_sub,
   output logic                           hero_clk_en,
   output logic [IDX_W-1:0]               owner,
   output logic                           err_timeout,
   output logic                           err_timeout_sticky
);

   // Encoding 2'd3 is undefined on the bus; it is carried like VALID.
   typedef enum logic [1:0] {
      CT_IDLE  = 2'd0,
      CT_VALID = 2'd1,
      CT_DONE  = 2'd2
   } cycle_type_e;

   typedef enum logic {
      ST_ARB,
      ST_LOCK
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [1:0]              ct_q, ct_d;
   logic [HERO_WIDTH-1:0]   wdat_q, wdat_d;
   logic [SUB_WIDTH-1:0]    sub_q, sub_d;
   logic                    clk_en_q, clk_en_d;
   logic                    err_q, err_d;
   logic                    sticky_q, sticky_d;

   logic [1:0]              ct_a   [NUM_REQ];
   logic [HERO_WIDTH-1:0]   wdat_a [NUM_REQ];
   logic [SUB_WIDTH-1:0]    sub_a  [NUM_REQ];
   logic [NUM_REQ-1:0]      eligible;

   logic                    slot_free;
   logic                    win_found;
   logic [IDX_W-1:0]        winner;
   logic [IDX_W-1:0]        sel;
   logic                    have_sel;
   logic                    accept;
   logic                    timeout;
   logic                    is_last;
   logic [IDX_W-1:0]        next_ptr;

   // Unpack the flat requester buses and flag requesters offering a real beat.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         ct_a[i]     = req_cycle_type[2*i +: 2];
         wdat_a[i]   = req_wdat[HERO_WIDTH*i +: HERO_WIDTH];
         sub_a[i]    = req_sub[SUB_WIDTH*i +: SUB_WIDTH];
         eligible[i] = req_valid[i] && (ct_a[i] != CT_IDLE);
      end
   end

   // Round-robin search: first eligible index at or after rr_ptr, wrapping
   // without a power-of-two modulo so any NUM_REQ works.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      winner    = rr_ptr_q;
      win_found = 1'b0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = 32'(rr_ptr_q) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!win_found && eligible[IDX_W'(idx)]) begin
            win_found = 1'b1;
            winner    = IDX_W'(idx);
         end
      end
   end

   // Handshake: the locked owner or the round-robin winner is accepted
   // whenever the output slot can take a beat.
   always_comb begin
      slot_free = out_ready || (ct_q == CT_IDLE);
      sel       = (state_q == ST_LOCK) ? owner_q : winner;
      have_sel  = (state_q == ST_LOCK) ? eligible[owner_q] : win_found;
      accept    = slot_free && have_sel;
      timeout   = accept && (state_q == ST_LOCK) && (ct_a[sel] != CT_DONE)
                  && (beat_cnt_q == CNT_W'(MAX_BURST - 1));
      is_last   = (ct_a[sel] == CT_DONE) || timeout;
      next_ptr  = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = rst_n && accept && (IDX_W'(i) == sel);
      end
   end

   // Next-state: output register load/bubble/hold, FSM, pointer and watchdog.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      ct_d       = ct_q;
      wdat_d     = wdat_q;
      sub_d      = sub_q;
      clk_en_d   = clk_en_q;
      err_d      = timeout;
      sticky_d   = sticky_q | timeout;
      if (slot_free) begin
         if (accept) begin
            ct_d     = timeout ? CT_DONE : ct_a[sel];
            wdat_d   = wdat_a[sel];
            sub_d    = sub_a[sel];
            clk_en_d = 1'b1;
            owner_d  = sel;
            if (is_last) begin
               state_d    = ST_ARB;
               beat_cnt_d = '0;
               rr_ptr_d   = next_ptr;
            end else begin
               state_d    = ST_LOCK;
               beat_cnt_d = (state_q == ST_ARB) ? CNT_W'(1) : beat_cnt_q + 1'b1;
            end
         end else begin
            ct_d     = CT_IDLE;
            wdat_d   = '0;
            sub_d    = '0;
            clk_en_d = 1'b0;
         end
      end
   end

   // State and registered outputs; async reset discards any partial transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ARB;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         ct_q       <= CT_IDLE;
         wdat_q     <= '0;
         sub_q      <= '0;
         clk_en_q   <= 1'b0;
         err_q      <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         ct_q       <= ct_d;
         wdat_q     <= wdat_d;
         sub_q      <= sub_d;
         clk_en_q   <= clk_en_d;
         err_q      <= err_d;
         sticky_q   <= sticky_d;
      end
   end

   assign hero_cycle_type    = ct_q;
   assign hero_wdat          = wdat_q;
   assign hero_sub           = sub_q;
   assign hero_clk_en        = clk_en_q;
   assign owner              = owner_q;
   assign err_timeout        = err_q;
   assign err_timeout_sticky = sticky_q;

endmodule

// File: tb/tb_hero_write_arb.sv
// Testbench for hero_write_arb: directed vector table, hand-written corner
// sequences (watchdog, async reset) and a randomized run against a model.
module tb_hero_write_arb;

   localparam int NR = 4;
   localparam int HW = 36;
   localparam int SW = 7;
   localparam int MB = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [2*NR-1:0]   req_cycle_type = '0;
   logic [HW*NR-1:0]  req_wdat = '0;
   logic [SW*NR-1:0]  req_sub = '0;
   logic [NR-1:0]     req_ready;
   logic              out_ready = 1'b0;
   logic [1:0]        hero_cycle_type;
   logic [HW-1:0]     hero_wdat;
   logic [SW-1:0]     hero_sub;
   logic              hero_clk_en;
   logic [1:0]        owner;
   logic              err_timeout;
   logic              err_timeout_sticky;

   int errors = 0;
   int checks = 0;

   hero_write_arb #(
      .NUM_REQ    (NR),
      .HERO_WIDTH (HW),
      .SUB_WIDTH  (SW),
      .MAX_BURST  (MB)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid          (req_valid),
      .req_cycle_type     (req_cycle_type),
      .req_wdat           (req_wdat),
      .req_sub            (req_sub),
      .req_ready          (req_ready),
      .out_ready          (out_ready),
      .hero_cycle_type    (hero_cycle_type),
      .hero_wdat          (hero_wdat),
      .hero_sub           (hero_sub),
      .hero_clk_en        (hero_clk_en),
      .owner              (owner),
      .err_timeout        (err_timeout),
      .err_timeout_sticky (err_timeout_sticky)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL tb_timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   typedef struct {
      logic [3:0]  v;
      logic [7:0]  ct;
      logic [35:0] wd;
      logic        orr;
      logic [3:0]  rdy;
      logic [1:0]  oct;
      logic [35:0] owd;
      logic [6:0]  osub;
      logic        oen;
      logic [1:0]  own;
      logic        err;
      logic        stk;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic [3:0] v, logic [7:0] ct, logic [35:0] wd, logic orr,
                               logic [3:0] rdy, logic [1:0] oct, logic [35:0] owd,
                               logic [6:0] osub, logic oen, logic [1:0] own,
                               logic err, logic stk);
      vec_t r;
      r = '{v, ct, wd, orr, rdy, oct, owd, osub, oen, own, err, stk};
      tbl.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Requester i sees data wd | i<<8 and sub 16*i + wd[3:0].
   task automatic drive(input logic [3:0] v, input logic [7:0] ct, input logic [35:0] wd,
                        input logic orr);
      req_valid      = v;
      req_cycle_type = ct;
      out_ready      = orr;
      for (int i = 0; i < NR; i++) begin
         req_wdat[i*HW +: HW] = wd | (36'(i) << 8);
         req_sub[i*SW +: SW]  = 7'(16*i) + 7'(wd[3:0]);
      end
   endtask

   task automatic apply_row(input vec_t r, input string tag);
      @(negedge clk);
      drive(r.v, r.ct, r.wd, r.orr);
      #1;
      chk({tag, ".ready"}, 64'(req_ready), 64'(r.rdy));
      @(posedge clk);
      #1;
      chk({tag, ".ctype"},  64'(hero_cycle_type),    64'(r.oct));
      chk({tag, ".wdat"},   64'(hero_wdat),          64'(r.owd));
      chk({tag, ".sub"},    64'(hero_sub),           64'(r.osub));
      chk({tag, ".clk_en"}, 64'(hero_clk_en),        64'(r.oen));
      chk({tag, ".owner"},  64'(owner),              64'(r.own));
      chk({tag, ".err"},    64'(err_timeout),        64'(r.err));
      chk({tag, ".sticky"}, 64'(err_timeout_sticky), 64'(r.stk));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".ready"},  64'(req_ready),          64'(0));
      chk({tag, ".ctype"},  64'(hero_cycle_type),    64'(0));
      chk({tag, ".wdat"},   64'(hero_wdat),          64'(0));
      chk({tag, ".sub"},    64'(hero_sub),           64'(0));
      chk({tag, ".clk_en"}, 64'(hero_clk_en),        64'(0));
      chk({tag, ".owner"},  64'(owner),              64'(0));
      chk({tag, ".err"},    64'(err_timeout),        64'(0));
      chk({tag, ".sticky"}, 64'(err_timeout_sticky), 64'(0));
   endtask

   // Reference model: spec-level transaction bookkeeping in plain integers.
   int          m_locked, m_owner, m_cnt, m_rr;
   logic [1:0]  m_ct;
   logic [35:0] m_wd;
   logic [6:0]  m_sub;
   logic        m_en, m_err, m_stk;

   function automatic bit elig(int j);
      return req_valid[j] && (req_cycle_type[2*j +: 2] != 2'd0);
   endfunction

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
      m_ct = 0; m_wd = 0; m_sub = 0; m_en = 0; m_err = 0; m_stk = 0;
   endtask

   task automatic model_step(output logic [3:0] rdy);
      bit         free;
      int         cand;
      int         beatno;
      logic [1:0] ct;
      bit         trunc;
      free = out_ready || (m_ct == 2'd0);
      cand = -1;
      if (m_locked != 0) begin
         if (elig(m_owner)) cand = m_owner;
      end else begin
         for (int k = 0; k < NR; k++) begin
            if (cand < 0 && elig((m_rr + k) % NR)) cand = (m_rr + k) % NR;
         end
      end
      rdy   = '0;
      m_err = 1'b0;
      if (free) begin
         if (cand >= 0) begin
            rdy[cand] = 1'b1;
            ct     = req_cycle_type[2*cand +: 2];
            beatno = (m_locked != 0) ? m_cnt + 1 : 1;
            trunc  = (ct != 2'd2) && (beatno == MB);
            m_ct    = trunc ? 2'd2 : ct;
            m_wd    = req_wdat[HW*cand +: HW];
            m_sub   = req_sub[SW*cand +: SW];
            m_en    = 1'b1;
            m_owner = cand;
            m_err   = trunc;
            if (trunc) m_stk = 1'b1;
            if (m_ct == 2'd2) begin
               m_locked = 0; m_cnt = 0; m_rr = (cand + 1) % NR;
            end else begin
               m_locked = 1; m_cnt = beatno;
            end
         end else begin
            m_ct = 2'd0; m_wd = '0; m_sub = '0; m_en = 1'b0;
         end
      end
   endtask

   initial begin
      vec_t r;
      int   tx_left [NR];
      logic [3:0] erdy;

      // Reset state, with requests active to confirm ready is held low.
      drive(4'b1111, 8'h55, 36'h0, 1'b1);
      #12;
      chk_reset_state("reset");
      @(negedge clk);
      drive(4'b0000, 8'h00, 36'h0, 1'b1);
      rst_n = 1'b1;

      //    v        ct     wd      or    rdy      oct   owd        osub   en    own   err   stk
      add(4'b0001, 8'h01, 36'h01, 1'b1, 4'b0001, 2'd1, 36'h001, 7'h01, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0001, 8'h01, 36'h02, 1'b1, 4'b0001, 2'd1, 36'h002, 7'h02, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0001, 8'h02, 36'h03, 1'b1, 4'b0001, 2'd2, 36'h003, 7'h03, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0000, 8'h00, 36'h00, 1'b1, 4'b0000, 2'd0, 36'h000, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
      add(4'b1000, 8'h80, 36'h04, 1'b1, 4'b1000, 2'd2, 36'h304, 7'h34, 1'b1, 2'd3, 1'b0, 1'b0);
      add(4'b0101, 8'h11, 36'h05, 1'b1, 4'b0001, 2'd1, 36'h005, 7'h05, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0101, 8'h12, 36'h06, 1'b1, 4'b0001, 2'd2, 36'h006, 7'h06, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0100, 8'h10, 36'h07, 1'b1, 4'b0100, 2'd1, 36'h207, 7'h27, 1'b1, 2'd2, 1'b0, 1'b0);
      add(4'b0100, 8'h20, 36'h08, 1'b1, 4'b0100, 2'd2, 36'h208, 7'h28, 1'b1, 2'd2, 1'b0, 1'b0);
      add(4'b1001, 8'h82, 36'h09, 1'b1, 4'b1000, 2'd2, 36'h309, 7'h39, 1'b1, 2'd3, 1'b0, 1'b0);
      add(4'b0001, 8'h02, 36'h0A, 1'b1, 4'b0001, 2'd2, 36'h00A, 7'h0A, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0000, 8'h00, 36'h00, 1'b1, 4'b0000, 2'd0, 36'h000, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
      add(4'b0011, 8'h05, 36'h0B, 1'b1, 4'b0010, 2'd1, 36'h10B, 7'h1B, 1'b1, 2'd1, 1'b0, 1'b0);
      add(4'b0001, 8'h05, 36'h0C, 1'b1, 4'b0000, 2'd0, 36'h000, 7'h00, 1'b0, 2'd1, 1'b0, 1'b0);
      add(4'b0001, 8'h05, 36'h0D, 1'b1, 4'b0000, 2'd0, 36'h000, 7'h00, 1'b0, 2'd1, 1'b0, 1'b0);
      add(4'b0011, 8'h05, 36'h0E, 1'b1, 4'b0010, 2'd1, 36'h10E, 7'h1E, 1'b1, 2'd1, 1'b0, 1'b0);
      add(4'b0011, 8'h09, 36'h0F, 1'b1, 4'b0010, 2'd2, 36'h10F, 7'h1F, 1'b1, 2'd1, 1'b0, 1'b0);
      add(4'b0001, 8'h02, 36'h10, 1'b1, 4'b0001, 2'd2, 36'h010, 7'h00, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0010, 8'h00, 36'h11, 1'b1, 4'b0000, 2'd0, 36'h000, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
      add(4'b0001, 8'h01, 36'h0A, 1'b1, 4'b0001, 2'd1, 36'h00A, 7'h0A, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0001, 8'h01, 36'h1B, 1'b0, 4'b0000, 2'd1, 36'h00A, 7'h0A, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0001, 8'h01, 36'h1B, 1'b0, 4'b0000, 2'd1, 36'h00A, 7'h0A, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0001, 8'h01, 36'h1B, 1'b0, 4'b0000, 2'd1, 36'h00A, 7'h0A, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0001, 8'h02, 36'h1C, 1'b1, 4'b0001, 2'd2, 36'h01C, 7'h0C, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0000, 8'h00, 36'h00, 1'b0, 4'b0000, 2'd2, 36'h01C, 7'h0C, 1'b1, 2'd0, 1'b0, 1'b0);
      add(4'b0000, 8'h00, 36'h00, 1'b1, 4'b0000, 2'd0, 36'h000, 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
      add(4'b0100, 8'h20, 36'h1D, 1'b0, 4'b0100, 2'd2, 36'h21D, 7'h2D, 1'b1, 2'd2, 1'b0, 1'b0);
      add(4'b0000, 8'h00, 36'h00, 1'b1, 4'b0000, 2'd0, 36'h000, 7'h00, 1'b0, 2'd2, 1'b0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply_row(tbl[i], $sformatf("vec%0d", i));
      end

      // Watchdog: req3 streams 6 VALID beats with MAX_BURST=4, then DONE.
      for (int k = 0; k < 6; k++) begin
         r = '{4'b1000, 8'h40, 36'(8'h30 + k), 1'b1, 4'b1000,
               (k == 3) ? 2'd2 : 2'd1, 36'(12'h330 + k), 7'(8'h30 + k),
               1'b1, 2'd3, 1'(k == 3), 1'(k >= 3)};
         apply_row(r, $sformatf("wdog%0d", k));
      end
      r = '{4'b1000, 8'h80, 36'h36, 1'b1, 4'b1000, 2'd2, 36'h336, 7'h36,
            1'b1, 2'd3, 1'b0, 1'b1};
      apply_row(r, "wdog_done");

      // Async reset mid-LOCK: outputs clear immediately, then ARB with rr_ptr=0.
      r = '{4'b0001, 8'h01, 36'h40, 1'b1, 4'b0001, 2'd1, 36'h040, 7'h00,
            1'b1, 2'd0, 1'b0, 1'b1};
      apply_row(r, "lock_pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("async_rst");
      @(negedge clk);
      drive(4'b0000, 8'h00, 36'h0, 1'b1);
      rst_n = 1'b1;
      r = '{4'b1010, 8'h88, 36'h41, 1'b1, 4'b0010, 2'd2, 36'h141, 7'h11,
            1'b1, 2'd1, 1'b0, 1'b0};
      apply_row(r, "post_rst");

      // Randomized traffic against the reference model from a fresh reset.
      @(negedge clk);
      rst_n = 1'b0;
      drive(4'b0000, 8'h00, 36'h0, 1'b1);
      model_reset();
      for (int i = 0; i < NR; i++) tx_left[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            if (tx_left[i] == 0 && $urandom_range(0, 3) == 0) tx_left[i] = $urandom_range(1, 7);
            if (tx_left[i] > 0 && ($urandom % 4) != 0) begin
               req_valid[i] = 1'b1;
               req_cycle_type[2*i +: 2] = (tx_left[i] == 1) ? 2'd2 : 2'd1;
            end else if (($urandom % 8) == 0) begin
               req_valid[i] = 1'b1;
               req_cycle_type[2*i +: 2] = 2'd0;
            end else begin
               req_valid[i] = 1'b0;
               req_cycle_type[2*i +: 2] = 2'($urandom_range(0, 2));
            end
            req_wdat[i*HW +: HW] = 36'({$urandom, $urandom});
            req_sub[i*SW +: SW]  = 7'($urandom);
         end
         out_ready = (($urandom % 4) != 0);
         #1;
         model_step(erdy);
         chk($sformatf("rnd%0d.ready", c), 64'(req_ready), 64'(erdy));
         for (int i = 0; i < NR; i++) begin
            if (erdy[i]) tx_left[i]--;
         end
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d.ctype", c),  64'(hero_cycle_type),    64'(m_ct));
         chk($sformatf("rnd%0d.wdat", c),   64'(hero_wdat),          64'(m_wd));
         chk($sformatf("rnd%0d.sub", c),    64'(hero_sub),           64'(m_sub));
         chk($sformatf("rnd%0d.clk_en", c), 64'(hero_clk_en),        64'(m_en));
         chk($sformatf("rnd%0d.owner", c),  64'(owner),              64'(m_owner));
         chk($sformatf("rnd%0d.err", c),    64'(err_timeout),        64'(m_err));
         chk($sformatf("rnd%0d.sticky", c), 64'(err_timeout_sticky), 64'(m_stk));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hero_write_arb.md
Name: hero_write_arb

Overview:
- Round-robin arbiter that shares one hero write bus (hero_write_t: cycle_type, wdat, another_type_reference, clk_en; 46 bits) between NUM_REQ requesters.
- Each grant holds for a whole multi-beat transaction (VALID…VALID, DONE) so beats from different requesters never interleave.
- Sits between the hero-bus producers and the single downstream hero sink, with one registered output stage and a burst-length watchdog.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HERO_WIDTH, 36, wdat width.
- SUB_WIDTH, 7, width of the another_type_reference (sub_def_t) field.
- MAX_BURST, 16, maximum beats per transaction, DONE beat included (2..256).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i presents a beat.
- req_cycle_type  in  2*NUM_REQ  CYCLE_TYPE_E per requester (IDLE=0, VALID=1, DONE=2).
- req_wdat  in  HERO_WIDTH*NUM_REQ  beat data per requester.
- req_sub  in  SUB_WIDTH*NUM_REQ  sub_def_t per requester.
- req_ready  out  NUM_REQ  beat from requester i is accepted this cycle.
- out_ready  in  1  downstream can take the output beat.
- hero_cycle_type  out  2  registered output cycle_type.
- hero_wdat  out  HERO_WIDTH  registered output data.
- hero_sub  out  SUB_WIDTH  registered output sub_def_t.
- hero_clk_en  out  1  1 on every real output beat.
- owner  out  clog2(NUM_REQ)  current or last granted requester.
- err_timeout  out  1  one-cycle pulse when the watchdog truncates a transaction.
- err_timeout_sticky  out  1  set by err_timeout; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): all outputs 0, hero_cycle_type=IDLE, state=ARB, rr_ptr=0, beat_cnt=0, req_ready=0.
- Requester i is eligible when req_valid[i]=1 and req_cycle_type[i]!=IDLE. req_valid with cycle_type IDLE is ignored and never accepted.
- slot_free = out_ready || (hero_cycle_type==IDLE).
- Output register loads only when slot_free.
  - Load with accepted beat: copy fields, hero_clk_en=1.
  - Load with no accepted beat: IDLE, data 0, clk_en 0 (bubble).
  - When slot_free=0: all outputs hold their values.
- Latency: 1 cycle from acceptance to output.
- State ARB:
  - Winner = first eligible index at or after rr_ptr, with wrap-around.
  - req_ready[winner]=slot_free; all other req_ready bits are 0. owner<=winner on acceptance.
  - Accepted beat DONE: single-beat transaction; stay ARB; rr_ptr<=winner+1 mod NUM_REQ.
  - Accepted beat VALID: go to LOCK; beat_cnt<=1.
- State LOCK:
  - req_ready[owner]=slot_free && eligible(owner); all other requesters are blocked.
  - Owner bubbles (not eligible) emit IDLE output beats and do not advance beat_cnt.
  - Accepted VALID beat: beat_cnt++.
  - Accepted DONE beat: go to ARB; rr_ptr<=owner+1.
  - Watchdog: if an accepted VALID beat would be beat number MAX_BURST, output it with cycle_type forced to DONE, pulse err_timeout, go to ARB, rr_ptr<=owner+1. The owner's later beats then compete as a new transaction.
- Backpressure: while out_ready=0 and the output is non-IDLE, no beats are accepted and state/pointers are frozen.
- beat_cnt is sized clog2(MAX_BURST+1).
- rr_ptr and owner wrap mod NUM_REQ; NUM_REQ need not be a power of 2.
- Reset during LOCK: returns to ARB immediately and discards the partial transaction; output reads IDLE.

Test Plan:
- Single requester 0 sends VALID,VALID,DONE with wdat 0x1,0x2,0x3 and out_ready=1 -> output VALID/1, VALID/2, DONE/3 on cycles +1..+3; clk_en=1 on those beats; req_ready[0] high for 3 cycles.
- Req0 and req2 both start 2-beat transactions at the same cycle with rr_ptr=0 -> req0's beats emitted, then req2's; no interleave; rr_ptr=3 at the end; next simultaneous start of req0 and req3 grants req3 first.
- Req1 in LOCK drops req_valid for 2 cycles mid-burst while req0 requests -> two IDLE output beats with clk_en=0; req_ready[0] stays 0; req1 resumes and finishes before req0 is granted.
- out_ready held 0 for 3 cycles while the output holds VALID/0xA -> output held unchanged; req_ready all 0; after release, the next beat appears 1 cycle later.
- MAX_BURST=4; req3 sends 6 VALID beats -> 4th output beat is DONE; err_timeout pulses one cycle; sticky=1; beats 5-6 re-arbitrate as a new transaction.
- Assert rst_n=0 asynchronously mid-LOCK -> outputs immediately IDLE/0; after release, state=ARB and rr_ptr=0.
